// File: rtl/core_pkg.sv
// Core-wide constants and types shared by the fetch-side memory blocks.
package core_pkg;

  localparam int XLEN        = 64;
  localparam int FETCH_WIDTH = 2;
  localparam logic [31:0] NOP_INSTR = 32'hD503201F;

  typedef enum logic {
    LOAD  = 1'b0,
    SERVE = 1'b1
  } imem_state_t;

  // One fetch response as it travels down the delay line.
  typedef struct packed {
    logic [FETCH_WIDTH-1:0][XLEN-1:0] pc;
    logic [FETCH_WIDTH-1:0][31:0]     data;
    logic                             fault;
  } imem_resp_t;

endpackage

// File: rtl/imem_resp_pipe.sv
// Fixed-length response delay line: LATENCY stages of {valid, pcs, words, fault}.
// Flush clears every in-flight valid; the incoming request still enters stage 0.
module imem_resp_pipe
  import core_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush_i,
  input  logic       valid_i,
  input  imem_resp_t resp_i,
  output logic       valid_o,
  output imem_resp_t resp_o
);

  logic [LATENCY-1:0] valid_q;
  imem_resp_t         stage_q [LATENCY];

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= valid_i;
      for (int i = 1; i < LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1] & ~flush_i;
      end
    end
  end

  // Payload only moves with a valid bit, so idle stages keep their contents.
  always_ff @(posedge clk) begin
    if (valid_i) begin
      stage_q[0] <= resp_i;
    end
    for (int i = 1; i < LATENCY; i++) begin
      if (valid_q[i-1]) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[LATENCY-1];
  assign resp_o  = stage_q[LATENCY-1];

endmodule

// File: rtl/imem_responder.sv
// Instruction memory model for a two-wide fetch: preload phase, then fixed-latency reads.
// Optional IMEM_BOUNDS_CHECK_EN: out-of-range slots return NOP with a fault; otherwise addresses wrap.
module imem_responder
  import core_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             imem_ren,
  input  logic [XLEN-1:0]                  imem_addr0,
  input  logic [XLEN-1:0]                  imem_addr1,
  input  logic                             imem_flush,
  input  logic                             ld_valid,
  input  logic [XLEN-1:0]                  ld_addr,
  input  logic [XLEN-1:0]                  ld_data,
  input  logic                             ld_done,
  output logic [XLEN-1:0]                  imem_rdata0,
  output logic [XLEN-1:0]                  imem_rdata1,
  output logic [FETCH_WIDTH-1:0][XLEN-1:0] imem_pc,
  output logic                             imem_valid,
  output logic                             ld_ready,
  output logic                             imem_fault
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  imem_state_t state_q, state_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic [IDX_W-1:0] ldIdx, rdIdx0, rdIdx1;
  logic             ldInRange, rdInRange0, rdInRange1;
  logic             ldWrite;
  logic             reqValid;
  imem_resp_t       reqResp;
  logic             respValid;
  imem_resp_t       respOut;

  logic [FETCH_WIDTH-1:0][XLEN-1:0] holdPc_q;
  logic [FETCH_WIDTH-1:0][31:0]     holdData_q;
  logic [31:0]                      outData0, outData1;
  logic                             unusedBits;

  always_comb begin
    state_d = state_q;
    if (state_q == LOAD && ld_done) begin
      state_d = SERVE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  assign ld_ready = (state_q == LOAD);

  assign ldIdx      = ld_addr[IDX_W+1:2];
  assign rdIdx0     = imem_addr0[IDX_W+1:2];
  assign rdIdx1     = imem_addr1[IDX_W+1:2];
  assign ldInRange  = ~|ld_addr[XLEN-1:IDX_W+2];
  assign rdInRange0 = ~|imem_addr0[XLEN-1:IDX_W+2];
  assign rdInRange1 = ~|imem_addr1[XLEN-1:IDX_W+2];

`ifdef IMEM_BOUNDS_CHECK_EN
  assign ldWrite = (state_q == LOAD) & ld_valid & ~reset & ldInRange;
`else
  assign ldWrite = (state_q == LOAD) & ld_valid & ~reset;
`endif

  // Storage has no reset: a core reset must not wipe the preloaded program.
  always_ff @(posedge clk) begin
    if (ldWrite) begin
      mem_q[ldIdx] <= ld_data[31:0];
    end
  end

  assign reqValid = imem_ren & (state_q == SERVE) & ~reset;

  always_comb begin
    reqResp         = '0;
    reqResp.pc[0]   = imem_addr0;
    reqResp.pc[1]   = imem_addr1;
    reqResp.data[0] = mem_q[rdIdx0];
    reqResp.data[1] = mem_q[rdIdx1];
`ifdef IMEM_BOUNDS_CHECK_EN
    if (!rdInRange0) begin
      reqResp.data[0] = NOP_INSTR;
    end
    if (!rdInRange1) begin
      reqResp.data[1] = NOP_INSTR;
    end
    reqResp.fault = ~rdInRange0 | ~rdInRange1;
`endif
  end

  imem_resp_pipe #(
    .LATENCY (LATENCY)
  ) u_resp_pipe (
    .clk     (clk),
    .reset   (reset),
    .flush_i (imem_flush),
    .valid_i (reqValid),
    .resp_i  (reqResp),
    .valid_o (respValid),
    .resp_o  (respOut)
  );

  // A redirect or reset in the presentation cycle kills the response on the spot.
  assign imem_valid = respValid & ~imem_flush & ~reset;
  assign imem_fault = imem_valid & respOut.fault;

  // Outputs show the last delivered response whenever no response is presented.
  always_ff @(posedge clk) begin
    if (reset) begin
      holdPc_q   <= '0;
      holdData_q <= '0;
    end else if (imem_valid) begin
      holdPc_q   <= respOut.pc;
      holdData_q <= respOut.data;
    end
  end

  assign outData0    = imem_valid ? respOut.data[0] : holdData_q[0];
  assign outData1    = imem_valid ? respOut.data[1] : holdData_q[1];
  assign imem_rdata0 = {{(XLEN-32){1'b0}}, outData0};
  assign imem_rdata1 = {{(XLEN-32){1'b0}}, outData1};
  assign imem_pc     = imem_valid ? respOut.pc : holdPc_q;

  assign unusedBits = ^{ld_data[XLEN-1:32], ld_addr[1:0], ldInRange, rdInRange0, rdInRange1};

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder (DEPTH_WORDS=1024, LATENCY=2) against a queue-based reference.
// Honours IMEM_BOUNDS_CHECK_EN in its expectations.
module tb_imem_responder;
  import core_pkg::*;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;
  localparam int NV    = 7;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset, imemRen, imemFlush, ldValid, ldDone;
  logic [XLEN-1:0] imemAddr0, imemAddr1, ldAddr, ldData;
  logic [XLEN-1:0] imemRdata0, imemRdata1;
  logic [FETCH_WIDTH-1:0][XLEN-1:0] imemPc;
  logic imemValid, ldReady, imemFault;

  imem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clock), .reset(reset), .imem_ren(imemRen), .imem_addr0(imemAddr0),
    .imem_addr1(imemAddr1), .imem_flush(imemFlush), .ld_valid(ldValid),
    .ld_addr(ldAddr), .ld_data(ldData), .ld_done(ldDone),
    .imem_rdata0(imemRdata0), .imem_rdata1(imemRdata1), .imem_pc(imemPc),
    .imem_valid(imemValid), .ld_ready(ldReady), .imem_fault(imemFault)
  );

  typedef struct {
    longint unsigned due;
    logic [63:0] pc0, pc1;
    logic [31:0] d0, d1;
    logic        fault;
  } expResp_t;

  typedef struct {
    logic [63:0] a0, a1;
    logic [31:0] e0, e1;
    logic        ef;
  } vec_t;

  int checks = 0;
  int failures = 0;
  longint unsigned cyc = 0;

  logic [31:0] refMem [DEPTH];
  logic        refLoad = 1'b1;
  expResp_t    pendQ[$];
  logic [63:0] heldPc0 = '0, heldPc1 = '0;
  logic [31:0] heldD0 = '0, heldD1 = '0;

  logic        expValid, expFault;
  logic [63:0] expPc0, expPc1;
  logic [31:0] expD0, expD1;

  logic        obsValid, obsFault, obsReady;
  logic [63:0] obsD0, obsD1, obsPc0, obsPc1;

  vec_t vecs [NV];

  function automatic void lookup(input logic [63:0] addr, output logic [31:0] d, output logic f);
`ifdef IMEM_BOUNDS_CHECK_EN
    if (addr >= 64'(DEPTH * 4)) begin
      d = NOP_INSTR;
      f = 1'b1;
    end else begin
      d = refMem[int'(addr / 4)];
      f = 1'b0;
    end
`else
    d = refMem[int'((addr / 4) % DEPTH)];
    f = 1'b0;
`endif
  endfunction

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic checkOutput();
    expValid = pendQ.size() > 0 && pendQ[0].due == cyc && !imemFlush && !reset;
    if (expValid) begin
      expD0 = pendQ[0].d0; expD1 = pendQ[0].d1;
      expPc0 = pendQ[0].pc0; expPc1 = pendQ[0].pc1;
      expFault = pendQ[0].fault;
    end else begin
      expD0 = heldD0; expD1 = heldD1;
      expPc0 = heldPc0; expPc1 = heldPc1;
      expFault = 1'b0;
    end
    obsValid = imemValid; obsFault = imemFault; obsReady = ldReady;
    obsD0 = imemRdata0; obsD1 = imemRdata1;
    obsPc0 = imemPc[0]; obsPc1 = imemPc[1];
    checkVal("imem_valid", 64'(obsValid), 64'(expValid));
    checkVal("ld_ready", 64'(obsReady), 64'(refLoad));
    checkVal("imem_fault", 64'(obsFault), 64'(expFault));
    checkVal("rdata0", obsD0, 64'(expD0));
    checkVal("rdata1", obsD1, 64'(expD1));
    checkVal("pc0", obsPc0, expPc0);
    checkVal("pc1", obsPc1, expPc1);
  endtask

  // Reference behaviour for the clock edge that ends the current cycle.
  task automatic modelStep();
    expResp_t e;
    if (pendQ.size() > 0 && pendQ[0].due == cyc) begin
      if (expValid) begin
        heldD0 = pendQ[0].d0; heldD1 = pendQ[0].d1;
        heldPc0 = pendQ[0].pc0; heldPc1 = pendQ[0].pc1;
      end
      void'(pendQ.pop_front());
    end
    if (reset) begin
      pendQ.delete();
      heldD0 = '0; heldD1 = '0; heldPc0 = '0; heldPc1 = '0;
      refLoad = 1'b1;
    end else begin
      if (imemFlush) pendQ.delete();
      if (refLoad) begin
        if (ldValid) begin
`ifdef IMEM_BOUNDS_CHECK_EN
          if (ldAddr < 64'(DEPTH * 4)) refMem[int'(ldAddr / 4)] = ldData[31:0];
`else
          refMem[int'((ldAddr / 4) % DEPTH)] = ldData[31:0];
`endif
        end
        if (ldDone) refLoad = 1'b0;
      end else if (imemRen) begin
        e.due = cyc + LAT;
        e.pc0 = imemAddr0;
        e.pc1 = imemAddr1;
        lookup(imemAddr0, e.d0, e.fault);
        begin
          logic f1;
          lookup(imemAddr1, e.d1, f1);
          e.fault = e.fault | f1;
        end
        pendQ.push_back(e);
      end
    end
    cyc++;
  endtask

  task automatic applyStimulus(input logic ren, input logic [63:0] a0, input logic [63:0] a1,
                               input logic flush, input logic ldv, input logic [63:0] la,
                               input logic [63:0] ld, input logic done, input logic rst);
    imemRen = ren; imemAddr0 = a0; imemAddr1 = a1; imemFlush = flush;
    ldValid = ldv; ldAddr = la; ldData = ld; ldDone = done; reset = rst;
    @(negedge clock);
    checkOutput();
    modelStep();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    vecs[0] = '{64'h0, 64'h4, 32'h11, 32'h22, 1'b0};
    vecs[1] = '{64'h8, 64'hC, 32'h33, 32'h44, 1'b0};
    vecs[2] = '{64'h4, 64'h0, 32'h22, 32'h11, 1'b0};
    vecs[3] = '{64'h3, 64'h6, 32'h11, 32'h22, 1'b0};
    vecs[4] = '{64'hC, 64'h8, 32'h44, 32'h33, 1'b0};
`ifdef IMEM_BOUNDS_CHECK_EN
    vecs[5] = '{64'h1000, 64'h4, NOP_INSTR, 32'h22, 1'b1};
    vecs[6] = '{64'h8, 64'h100C, 32'h33, NOP_INSTR, 1'b1};
`else
    vecs[5] = '{64'h1000, 64'h4, 32'h11, 32'h22, 1'b0};
    vecs[6] = '{64'h8, 64'h100C, 32'h33, 32'h44, 1'b0};
`endif

    reset = 1'b1; imemRen = 0; imemFlush = 0; ldValid = 0; ldDone = 0;
    imemAddr0 = '0; imemAddr1 = '0; ldAddr = '0; ldData = '0;
    @(posedge clock);
    #1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Requests during LOAD must never produce a response.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 0, 4, 0, 0, 0, 0, 0, 0);
      checkVal("load_no_valid", 64'(obsValid), 64'd0);
      checkVal("load_ready", 64'(obsReady), 64'd1);
    end

    // Full preload; the last write coincides with ld_done.
    for (int i = 0; i < DEPTH; i++) begin
      logic [63:0] d;
      d = (i < 4) ? 64'(32'h11 * (i + 1)) : {$urandom, $urandom};
      applyStimulus(1'($urandom_range(0, 1)), 0, 4, 0, 1, 64'(i * 4 + $urandom_range(0, 3)), d,
                    i == DEPTH - 1, 0);
    end
    idle(1);
    checkVal("serve_ready", 64'(obsReady), 64'd0);

    // Back-to-back vector table.
    for (int k = 0; k < NV + LAT; k++) begin
      if (k < NV) applyStimulus(1, vecs[k].a0, vecs[k].a1, 0, 0, 0, 0, 0, 0);
      else        idle(1);
      if (k >= LAT) begin
        checkVal("vec_valid", 64'(obsValid), 64'd1);
        checkVal("vec_d0", obsD0, 64'(vecs[k-LAT].e0));
        checkVal("vec_d1", obsD1, 64'(vecs[k-LAT].e1));
        checkVal("vec_pc0", obsPc0, vecs[k-LAT].a0);
        checkVal("vec_pc1", obsPc1, vecs[k-LAT].a1);
        checkVal("vec_fault", 64'(obsFault), 64'(vecs[k-LAT].ef));
      end
    end
    idle(2);

    // Flush one cycle after a request; the request riding with the flush survives.
    applyStimulus(1, 64'h0, 64'h4, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 64'h8, 64'hC, 1, 0, 0, 0, 0, 0);
    checkVal("flush_v1", 64'(obsValid), 64'd0);
    idle(1);
    checkVal("flush_v2", 64'(obsValid), 64'd0);
    idle(1);
    checkVal("flush_v3", 64'(obsValid), 64'd1);
    checkVal("flush_d0", obsD0, 64'h33);
    checkVal("flush_d1", obsD1, 64'h44);
    idle(2);
    checkVal("hold_d0", obsD0, 64'h33);

    // Randomized traffic with occasional redirects and ignored preload strobes.
    for (int i = 0; i < 400; i++) begin
      logic [63:0] a0, a1;
      a0 = ($urandom_range(0, 9) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 'h1FFF));
      a1 = ($urandom_range(0, 9) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 'h1FFF));
      applyStimulus($urandom_range(0, 9) < 7, a0, a1, $urandom_range(0, 9) == 0,
                    $urandom_range(0, 9) == 0, 64'h0, 64'hBAD, 0, 0);
    end
    idle(LAT + 1);

    // Reset in the middle of a request; storage survives, in-flight data does not.
    applyStimulus(1, 64'h0, 64'h4, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      checkVal("rst_no_valid", 64'(obsValid), 64'd0);
      checkVal("rst_ready", 64'(obsReady), 64'd1);
    end
    applyStimulus(0, 0, 0, 0, 1, 64'(DEPTH * 4 + 'h10), 64'hABCD, 1, 0);
    applyStimulus(1, 64'h0, 64'h10, 0, 0, 0, 0, 0, 0);
    idle(LAT);
    checkVal("rst_valid", 64'(obsValid), 64'd1);
    checkVal("rst_keep_d0", obsD0, 64'h11);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
